// File: rtl/data_cache_responder_if.sv
// Bus bundle for the data cache: pipeline load/store handshake plus the
// word-serial main-memory beat interface. The cache takes the slave view,
// the surrounding pipeline/memory environment takes the master view.
interface data_cache_responder_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
);
  // Pipeline side
  logic                     DATA_CACHE_STALL;
  logic [ADDRESS_WIDTH-1:0] DATA_CACHE_READ_ADDRESS;
  logic                     DATA_CACHE_LOAD;
  logic [ADDRESS_WIDTH-1:0] DATA_CACHE_WRITE_ADDRESS;
  logic [DATA_WIDTH-1:0]    DATA_CACHE_WRITE_DATA;
  logic                     DATA_CACHE_STORE;
  logic                     DATA_CACHE_READY;
  logic [DATA_WIDTH-1:0]    DATA_CACHE_READ_DATA;
  // Main-memory side
  logic                     MEM_REQ;
  logic                     MEM_WRITE;
  logic [ADDRESS_WIDTH-1:0] MEM_ADDRESS;
  logic [DATA_WIDTH-1:0]    MEM_WRITE_DATA;
  logic                     MEM_ACK;
  logic [DATA_WIDTH-1:0]    MEM_READ_DATA;

  modport slave (
    input  DATA_CACHE_STALL, DATA_CACHE_READ_ADDRESS, DATA_CACHE_LOAD,
           DATA_CACHE_WRITE_ADDRESS, DATA_CACHE_WRITE_DATA, DATA_CACHE_STORE,
           MEM_ACK, MEM_READ_DATA,
    output DATA_CACHE_READY, DATA_CACHE_READ_DATA,
           MEM_REQ, MEM_WRITE, MEM_ADDRESS, MEM_WRITE_DATA
  );

  modport master (
    output DATA_CACHE_STALL, DATA_CACHE_READ_ADDRESS, DATA_CACHE_LOAD,
           DATA_CACHE_WRITE_ADDRESS, DATA_CACHE_WRITE_DATA, DATA_CACHE_STORE,
           MEM_ACK, MEM_READ_DATA,
    input  DATA_CACHE_READY, DATA_CACHE_READ_DATA,
           MEM_REQ, MEM_WRITE, MEM_ADDRESS, MEM_WRITE_DATA
  );
endinterface

// File: rtl/data_cache_responder.sv
// Direct-mapped, write-back, write-allocate data cache. Hits complete in the
// lookup cycle; misses run an optional 4-beat writeback of the dirty victim
// followed by a 4-beat refill, then the held request re-looks-up and hits.
module data_cache_responder #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int INDEX_BITS    = 6,
  parameter int WORD_BITS     = 2
) (
  input logic                   CLK,
  input logic                   RST,
  data_cache_responder_if.slave bus
);
  localparam int OFFSET_BITS = 2;
  localparam int TAG_BITS    = ADDRESS_WIDTH - INDEX_BITS - WORD_BITS - OFFSET_BITS;
  localparam int LINES       = 1 << INDEX_BITS;
  localparam int WORDS       = 1 << WORD_BITS;

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

  state_t                   state_q;
  logic [WORD_BITS-1:0]     beat_q;
  logic [TAG_BITS-1:0]      miss_tag_q;
  logic [INDEX_BITS-1:0]    miss_idx_q;
  logic [LINES-1:0]         valid_q;
  logic [LINES-1:0]         dirty_q;
  logic [DATA_WIDTH-1:0]    read_data_q;
  logic                     mem_req_q;
  logic                     mem_write_q;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0]    mem_wdata_q;

  // Tag and data storage; no reset, validity lives in valid_q.
  logic [TAG_BITS-1:0]      tag_mem  [LINES];
  logic [DATA_WIDTH-1:0]    data_mem [LINES*WORDS];

  logic                     store_sel;
  logic                     req_any;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic [WORD_BITS-1:0]     req_word;
  logic [INDEX_BITS-1:0]    req_idx;
  logic [TAG_BITS-1:0]      req_tag;
  logic                     lookup;
  logic                     hit;
  logic                     ready;
  logic                     miss;
  logic                     mem_ack;
  logic                     last_beat;
  logic [WORD_BITS-1:0]     beat_next;
  logic [TAG_BITS-1:0]      victim_tag;
  logic                     unused_offset;

  // Store wins over a simultaneous load; the load is simply dropped.
  assign store_sel = bus.DATA_CACHE_STORE;
  assign req_any   = bus.DATA_CACHE_STORE | bus.DATA_CACHE_LOAD;
  assign req_addr  = store_sel ? bus.DATA_CACHE_WRITE_ADDRESS : bus.DATA_CACHE_READ_ADDRESS;
  assign req_word  = req_addr[OFFSET_BITS +: WORD_BITS];
  assign req_idx   = req_addr[OFFSET_BITS+WORD_BITS +: INDEX_BITS];
  assign req_tag   = req_addr[ADDRESS_WIDTH-1 -: TAG_BITS];
  // Byte offset is ignored: misaligned accesses act on the containing word.
  assign unused_offset = ^req_addr[OFFSET_BITS-1:0];

  assign lookup     = (state_q == IDLE) && !bus.DATA_CACHE_STALL && req_any;
  assign hit        = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign ready      = lookup && hit;
  assign miss       = lookup && !hit;
  assign mem_ack    = mem_req_q && bus.MEM_ACK;
  assign last_beat  = (beat_q == WORD_BITS'(WORDS - 1));
  assign beat_next  = beat_q + WORD_BITS'(1);
  // Victim tag stays in the array until the refill's last beat overwrites it.
  assign victim_tag = tag_mem[miss_idx_q];

  assign bus.DATA_CACHE_READY     = ready;
  assign bus.DATA_CACHE_READ_DATA = read_data_q;
  assign bus.MEM_REQ              = mem_req_q;
  assign bus.MEM_WRITE            = mem_write_q;
  assign bus.MEM_ADDRESS          = mem_addr_q;
  assign bus.MEM_WRITE_DATA       = mem_wdata_q;

  // Control FSM: hit handling, miss latching and beat sequencing with registered memory outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      miss_tag_q  <= '0;
      miss_idx_q  <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
      read_data_q <= '0;
      mem_req_q   <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ready) begin
            if (store_sel) begin
              dirty_q[req_idx] <= 1'b1;
            end else begin
              read_data_q <= data_mem[{req_idx, req_word}];
            end
          end else if (miss) begin
            miss_tag_q <= req_tag;
            miss_idx_q <= req_idx;
            beat_q     <= '0;
            mem_req_q  <= 1'b1;
            if (valid_q[req_idx] && dirty_q[req_idx]) begin
              state_q     <= WRITEBACK;
              mem_write_q <= 1'b1;
              mem_addr_q  <= {tag_mem[req_idx], req_idx, {WORD_BITS{1'b0}}, {OFFSET_BITS{1'b0}}};
              mem_wdata_q <= data_mem[{req_idx, {WORD_BITS{1'b0}}}];
            end else begin
              state_q     <= REFILL;
              mem_write_q <= 1'b0;
              mem_addr_q  <= {req_tag, req_idx, {WORD_BITS{1'b0}}, {OFFSET_BITS{1'b0}}};
            end
          end
        end
        WRITEBACK: begin
          if (mem_ack) begin
            if (last_beat) begin
              state_q     <= REFILL;
              beat_q      <= '0;
              mem_write_q <= 1'b0;
              mem_addr_q  <= {miss_tag_q, miss_idx_q, {WORD_BITS{1'b0}}, {OFFSET_BITS{1'b0}}};
              mem_wdata_q <= '0;
            end else begin
              beat_q      <= beat_next;
              mem_addr_q  <= {victim_tag, miss_idx_q, beat_next, {OFFSET_BITS{1'b0}}};
              mem_wdata_q <= data_mem[{miss_idx_q, beat_next}];
            end
          end
        end
        REFILL: begin
          if (mem_ack) begin
            if (last_beat) begin
              state_q             <= IDLE;
              beat_q              <= '0;
              valid_q[miss_idx_q] <= 1'b1;
              dirty_q[miss_idx_q] <= 1'b0;
              mem_req_q           <= 1'b0;
              mem_addr_q          <= '0;
            end else begin
              beat_q     <= beat_next;
              mem_addr_q <= {miss_tag_q, miss_idx_q, beat_next, {OFFSET_BITS{1'b0}}};
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Array writes: store hits and refill beats (mutually exclusive by state); tag installed on the last refill beat.
  always_ff @(posedge CLK) begin
    if (ready && store_sel) begin
      data_mem[{req_idx, req_word}] <= bus.DATA_CACHE_WRITE_DATA;
    end else if ((state_q == REFILL) && mem_ack) begin
      data_mem[{miss_idx_q, beat_q}] <= bus.MEM_READ_DATA;
    end
    if ((state_q == REFILL) && mem_ack && last_beat) begin
      tag_mem[miss_idx_q] <= miss_tag_q;
    end
  end
endmodule

// File: tb/tb_data_cache_responder.sv
// Self-checking bench: directed vector table, hand-written multi-cycle
// sequences (slow memory, reset mid-burst) and randomized traffic checked
// against a line-level cache model with its own copy of main memory.
module tb_data_cache_responder;
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  data_cache_responder_if bus ();

  data_cache_responder dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  beat_t seen_q[$];
  beat_t exp_q[$];

  // Memory responder state
  logic [31:0] resp_mem [logic [31:0]];
  int          ack_mode = 0;   // 0 = ack tied high, 1 = random, 2 = ack after 2 wait cycles
  int          wait_cnt = 0;
  bit          prev_wait = 0;
  logic [31:0] prev_addr, prev_wdata;
  bit          prev_wr;

  // Reference model: per-line state and a private image of main memory
  bit          m_valid [64];
  bit          m_dirty [64];
  logic [31:0] m_tag   [64];
  logic [31:0] m_data  [64][4];
  logic [31:0] m_mem   [logic [31:0]];
  logic [31:0] m_rd;

  function automatic logic [31:0] resp_rd(input logic [31:0] a);
    return resp_mem.exists(a) ? resp_mem[a] : a + 32'h1000;
  endfunction

  function automatic logic [31:0] model_mem_rd(input logic [31:0] a);
    return m_mem.exists(a) ? m_mem[a] : a + 32'h1000;
  endfunction

  // Completed beats, as seen by main memory
  always @(posedge CLK) begin
    if (bus.MEM_REQ && bus.MEM_ACK) begin
      seen_q.push_back('{bus.MEM_WRITE, bus.MEM_ADDRESS,
                         bus.MEM_WRITE ? bus.MEM_WRITE_DATA : bus.MEM_READ_DATA});
      if (bus.MEM_WRITE) resp_mem[bus.MEM_ADDRESS] = bus.MEM_WRITE_DATA;
    end
  end

  // Drive ACK/read data and check that a stalled beat holds its outputs
  always @(negedge CLK) begin
    if (prev_wait && !RST) begin
      checks++;
      if (!bus.MEM_REQ || bus.MEM_ADDRESS !== prev_addr || bus.MEM_WRITE !== prev_wr ||
          bus.MEM_WRITE_DATA !== prev_wdata) begin
        errors++;
        $display("FAIL mem_hold: got req=%0b addr=%h wr=%0b wdata=%h, required req=1 addr=%h wr=%0b wdata=%h",
                 bus.MEM_REQ, bus.MEM_ADDRESS, bus.MEM_WRITE, bus.MEM_WRITE_DATA,
                 prev_addr, prev_wr, prev_wdata);
      end
    end
    case (ack_mode)
      0: bus.MEM_ACK = 1'b1;
      1: bus.MEM_ACK = 1'($urandom_range(0, 1));
      default: begin
        if (!bus.MEM_REQ) begin
          bus.MEM_ACK = 1'b0;
          wait_cnt = 0;
        end else if (wait_cnt == 2) begin
          bus.MEM_ACK = 1'b1;
          wait_cnt = 0;
        end else begin
          bus.MEM_ACK = 1'b0;
          wait_cnt++;
        end
      end
    endcase
    bus.MEM_READ_DATA = resp_rd(bus.MEM_ADDRESS);
    prev_wait  = bus.MEM_REQ && !bus.MEM_ACK;
    prev_addr  = bus.MEM_ADDRESS;
    prev_wr    = bus.MEM_WRITE;
    prev_wdata = bus.MEM_WRITE_DATA;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
    m_rd = 32'h0;
  endtask

  // Applies one request to the model; pen = cycles until READY with ACK tied high.
  task automatic model_access(input bit st, input logic [31:0] addr, input logic [31:0] wd,
                              output int pen);
    int          idx  = int'((addr / 16) % 64);
    int          w    = int'((addr / 4) % 4);
    logic [31:0] tag  = addr / 1024;
    logic [31:0] base = addr & ~32'hF;
    logic [31:0] vbase;
    pen = 0;
    if (!(m_valid[idx] && m_tag[idx] == tag)) begin
      pen = 5;
      if (m_valid[idx] && m_dirty[idx]) begin
        pen = 9;
        vbase = m_tag[idx] * 32'd1024 + 32'(idx) * 32'd16;
        for (int k = 0; k < 4; k++) begin
          exp_q.push_back('{1'b1, vbase + 32'(4 * k), m_data[idx][k]});
          m_mem[vbase + 32'(4 * k)] = m_data[idx][k];
        end
      end
      for (int k = 0; k < 4; k++) begin
        m_data[idx][k] = model_mem_rd(base + 32'(4 * k));
        exp_q.push_back('{1'b0, base + 32'(4 * k), m_data[idx][k]});
      end
      m_valid[idx] = 1;
      m_dirty[idx] = 0;
      m_tag[idx]   = tag;
    end
    if (st) begin
      m_data[idx][w] = wd;
      m_dirty[idx]   = 1;
    end else begin
      m_rd = m_data[idx][w];
    end
  endtask

  task automatic cmp_beats(input string name);
    checks++;
    if (seen_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s/beat_count: got %0d, required %0d", name, seen_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[k]) begin
        checks++;
        if (seen_q[k] !== exp_q[k]) begin
          errors++;
          $display("FAIL %s/beat%0d: got wr=%0b addr=%h data=%h, required wr=%0b addr=%h data=%h",
                   name, k, seen_q[k].wr, seen_q[k].addr, seen_q[k].data,
                   exp_q[k].wr, exp_q[k].addr, exp_q[k].data);
        end
      end
    end
    seen_q.delete();
    exp_q.delete();
  endtask

  // Holds the request until READY; lat = cycles spent waiting.
  task automatic xact(input bit st, input bit ld, input logic [31:0] waddr, input logic [31:0] raddr,
                      input logic [31:0] wd, input int stall_n, output int lat);
    int n = 0;
    @(negedge CLK);
    bus.DATA_CACHE_STORE         = st;
    bus.DATA_CACHE_LOAD          = ld;
    bus.DATA_CACHE_WRITE_ADDRESS = waddr;
    bus.DATA_CACHE_READ_ADDRESS  = raddr;
    bus.DATA_CACHE_WRITE_DATA    = wd;
    bus.DATA_CACHE_STALL         = (stall_n > 0);
    forever begin
      #1;
      if (bus.DATA_CACHE_READY) break;
      if (n >= 400) begin
        checks++;
        errors++;
        $display("FAIL ready_timeout: got no READY in %0d cycles, required READY", n);
        break;
      end
      @(negedge CLK);
      n++;
      if (n >= stall_n) bus.DATA_CACHE_STALL = 1'b0;
    end
    lat = n;
    @(negedge CLK);
    bus.DATA_CACHE_STORE = 1'b0;
    bus.DATA_CACHE_LOAD  = 1'b0;
    bus.DATA_CACHE_STALL = 1'b0;
  endtask

  task automatic check_xact(input string name, input bit st, input bit ld, input logic [31:0] waddr,
                            input logic [31:0] raddr, input logic [31:0] wd, input int stall_n,
                            input bit chk_lat, output int lat);
    int pen;
    model_access(st, st ? waddr : raddr, wd, pen);
    xact(st, ld, waddr, raddr, wd, stall_n, lat);
    chk({name, "/rdata"}, bus.DATA_CACHE_READ_DATA, m_rd);
    if (chk_lat) chk({name, "/latency"}, 32'(lat), 32'(pen + stall_n));
    cmp_beats(name);
    $display("txn %s st=%0b ld=%0b waddr=%h raddr=%h wdata=%h stall=%0d lat=%0d rdata=%h",
             name, st, ld, waddr, raddr, wd, stall_n, lat, bus.DATA_CACHE_READ_DATA);
  endtask

  typedef struct {
    bit          st;
    bit          ld;
    logic [31:0] waddr;
    logic [31:0] raddr;
    logic [31:0] wdata;
    int          stall;
    int          exp_lat;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [7];

  task automatic run_vec(input int i);
    int    lat;
    string name;
    name = $sformatf("vec%0d", i);
    check_xact(name, vecs[i].st, vecs[i].ld, vecs[i].waddr, vecs[i].raddr, vecs[i].wdata,
               vecs[i].stall, 1'b1, lat);
    chk({name, "/table_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
    chk({name, "/table_rd"}, bus.DATA_CACHE_READ_DATA, vecs[i].exp_rd);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int n;
    logic [31:0] wa, ra;
    int op;

    //           st  ld  waddr          raddr          wdata          stall lat rdata
    vecs[0] = '{1'b0, 1'b1, 32'h0,        32'h0000_0104, 32'h0,        0, 5, 32'h0000_1104};
    vecs[1] = '{1'b0, 1'b1, 32'h0,        32'h0000_0108, 32'h0,        0, 0, 32'h0000_1108};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0104, 32'h0,        32'hDEAD_BEEF, 0, 0, 32'h0000_1108};
    vecs[3] = '{1'b0, 1'b1, 32'h0,        32'h0000_0504, 32'h0,        0, 9, 32'h0000_1504};
    vecs[4] = '{1'b0, 1'b1, 32'h0,        32'h0000_0108, 32'h0,        0, 5, 32'h0000_1108};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_0108, 32'h0000_010C, 32'h0000_0055, 1, 1, 32'h0000_1108};
    vecs[6] = '{1'b0, 1'b1, 32'h0,        32'h0000_0108, 32'h0,        0, 0, 32'h0000_0055};

    RST = 1'b1;
    bus.DATA_CACHE_STALL         = 1'b0;
    bus.DATA_CACHE_LOAD          = 1'b0;
    bus.DATA_CACHE_STORE         = 1'b0;
    bus.DATA_CACHE_READ_ADDRESS  = '0;
    bus.DATA_CACHE_WRITE_ADDRESS = '0;
    bus.DATA_CACHE_WRITE_DATA    = '0;
    bus.MEM_ACK                  = 1'b0;
    bus.MEM_READ_DATA            = '0;
    model_reset();

    // Reset state, with a load already presented
    repeat (3) @(negedge CLK);
    bus.DATA_CACHE_LOAD         = 1'b1;
    bus.DATA_CACHE_READ_ADDRESS = 32'h0000_0104;
    #1;
    chk("reset/ready", 32'(bus.DATA_CACHE_READY), 32'h0);
    chk("reset/read_data", bus.DATA_CACHE_READ_DATA, 32'h0);
    chk("reset/mem_req", 32'(bus.MEM_REQ), 32'h0);
    chk("reset/mem_write", 32'(bus.MEM_WRITE), 32'h0);
    chk("reset/mem_address", bus.MEM_ADDRESS, 32'h0);
    chk("reset/mem_write_data", bus.MEM_WRITE_DATA, 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    bus.DATA_CACHE_LOAD = 1'b0;

    for (int i = 0; i < 4; i++) run_vec(i);

    // Slow memory: ACK low two cycles per beat; four beats of three cycles each
    ack_mode = 2;
    check_xact("slow_refill", 1'b0, 1'b1, 32'h0, 32'h0000_2000, 32'h0, 0, 1'b0, lat);
    chk("slow_refill/latency", 32'(lat), 32'd13);
    ack_mode = 0;

    // Reset in the middle of a refill, while beat 2 is on the bus
    @(negedge CLK);
    bus.DATA_CACHE_LOAD         = 1'b1;
    bus.DATA_CACHE_READ_ADDRESS = 32'h0000_3040;
    n = 0;
    while (seen_q.size() < 2 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("rst_mid/beats_before", 32'(seen_q.size()), 32'd2);
    chk("rst_mid/beat2_addr", bus.MEM_ADDRESS, 32'h0000_3048);
    RST = 1'b1;
    #1;
    chk("rst_mid/mem_req", 32'(bus.MEM_REQ), 32'h0);
    chk("rst_mid/read_data", bus.DATA_CACHE_READ_DATA, 32'h0);
    chk("rst_mid/ready", 32'(bus.DATA_CACHE_READY), 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    bus.DATA_CACHE_LOAD = 1'b0;
    seen_q.delete();
    model_reset();
    check_xact("rst_mid/reload", 1'b0, 1'b1, 32'h0, 32'h0000_3040, 32'h0, 0, 1'b1, lat);

    for (int i = 4; i < 7; i++) run_vec(i);

    // Randomized traffic over a few indices and tags to force hits, conflicts and writebacks
    ack_mode = 1;
    for (int t = 0; t < 150; t++) begin
      wa = 32'($urandom_range(0, 3)) * 32'd1024 + 32'($urandom_range(0, 3)) * 32'd16 +
           32'($urandom_range(0, 3)) * 32'd4 + 32'($urandom_range(0, 3));
      ra = 32'($urandom_range(0, 3)) * 32'd1024 + 32'($urandom_range(0, 3)) * 32'd16 +
           32'($urandom_range(0, 3)) * 32'd4 + 32'($urandom_range(0, 3));
      op = int'($urandom_range(0, 3));
      check_xact($sformatf("rand%0d", t), op == 0 || op == 2, op != 0, wa, ra, $urandom,
                 int'($urandom_range(0, 2)), 1'b0, lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
